dcm_freq_scheduler: RTL and testbench
=====================================

Name: dcm_freq_scheduler

Overview:
- Owns the DCM_CLKGEN dynamic-programming port and decides when, and to what value, the hashing-core multiplier changes.
- Arbitrates between two requesters:
  - host set-clock commands, decoded upstream from UART work packets;
  - a thermal-throttle cap.
- Ramps frequency in bounded steps with a settle interval, serialises each D/M frame, and reports status back to the host-facing logic.

Parameters:
- MAXIMUM_MULTIPLIER, 64: upper clamp for any requested M.
- MINIMUM_MULTIPLIER, 2: lower clamp for any requested M.
- INITIAL_MULTIPLIER, 16: target after reset.
- DIVIDER, 8: fixed D; the frame carries DIVIDER-1.
- MAX_STEP, 4: largest upward multiplier change per programming cycle.
- SETTLE_CYCLES, 4096: clk cycles to wait after prog_done before the next step.
- TIMEOUT_CYCLES, 65535: maximum clk cycles to wait for dcm_prog_done.

Ports:
- clk, in, 1: system clock; also drives DCM PROGCLK.
- rst_n, in, 1: asynchronous active-low reset.
- host_req, in, 1: one-cycle pulse; latch host_mult.
- host_mult, in, 8: requested multiplier.
- thermal_alarm, in, 1: level; cap is active while high.
- thermal_mult, in, 8: cap value while the alarm is high.
- dcm_prog_done, in, 1: PROGDONE from the DCM.
- dcm_locked, in, 1: LOCKED from the DCM.
- dcm_prog_en, out, 1: PROGEN.
- dcm_prog_data, out, 1: PROGDATA.
- busy, out, 1: high in every state except IDLE.
- current_mult, out, 8: last successfully programmed M; 0 means never programmed.
- target_mult, out, 8: clamped host target.
- prog_error, out, 1: sticky; set on timeout or on loss of lock at the end of settle; cleared by the next host_req.

Behaviour:
- Reset values: dcm_prog_en=0, dcm_prog_data=0, busy=0, current_mult=0, target_mult=INITIAL_MULTIPLIER, prog_error=0. FSM resets to IDLE.
- Reset mid-frame: the frame is abandoned; the DCM ignores the partial frame.
- Clamping: both host_mult and thermal_mult are clamped to [MINIMUM_MULTIPLIER, MAXIMUM_MULTIPLIER] using 8-bit unsigned compares.
- host_req: registers the clamped value into target_mult on the same edge, whether or not busy. The last request wins.
- Effective target (eff): eff = thermal_alarm ? min(target_mult, clamped thermal_mult) : target_mult.
- Step selection in IDLE, when eff != current_mult:
  - current_mult==0: next = eff.
  - eff < current_mult: next = eff (immediate down-step).
  - otherwise: next = min(eff, current_mult+MAX_STEP), computed in 9 bits to avoid wrap.
- FSM:
  - IDLE -> LOAD_D: latch next; busy=1.
  - LOAD_D: 10 cycles. {en,data}=11, then 10, then the 8 bits of DIVIDER-1 LSB-first with en=1.
  - GAP1: 3 cycles, en=0.
  - LOAD_M: 10 cycles. {en,data}=11, 11, then the 8 bits of next-1 LSB-first.
  - GAP2: 2 cycles, en=0.
  - GO: 1 cycle, {en,data}=10.
  - WAIT_DONE: en=0.
    - On dcm_prog_done: current_mult<=next, go to SETTLE.
    - After TIMEOUT_CYCLES without done: prog_error=1, current_mult unchanged, go to SETTLE.
  - SETTLE: count SETTLE_CYCLES. On the final cycle, if dcm_locked==0, set prog_error=1. Then go to IDLE.
- Frame timing: the frame is 26 clk cycles from LOAD_D entry to the end of GO. Outputs are registered.
- Simultaneous events:
  - thermal_alarm rising mid-frame does not abort the frame. The next IDLE evaluation steps down directly.
  - host_req on the IDLE->LOAD_D edge does not alter the latched next value.
- Error recovery: prog_error never blocks scheduling; IDLE keeps retrying toward eff.

Optional Feature:
- Macro DCM_RAMP_EN.
  - Defined: upward steps are limited to MAX_STEP, as in the step-selection rule above.
  - Undefined: next = eff in all cases; MAX_STEP is unused; SETTLE still applies.

Decomposition:
- Package dcm_ctrl_pkg holds:
  - FSM state encoding;
  - LOAD_D/LOAD_M command-bit constants (2'b01, 2'b11, transmitted first bit first as in the frame definition);
  - frame-length constants (10, 3, 2).
- Sub-module dcm_prog_serializer:
  - inputs start, is_m, value[7:0];
  - outputs en, data, frame_done;
  - shifts one 10-cycle LOAD frame.
- The scheduler FSM sequences two serializer frames plus the gaps and GO.

Test Plan:
- Reset release, prog_done returned 3 cycles after GO: one programming cycle, M frame carries 15 and D frame carries 7; current_mult=16; busy low after 26+3+4096 cycles.
- host_mult=40 from current 16 with ramp enabled: successive current_mult values 20, 24, 28, 32, 36, 40, each separated by at least SETTLE_CYCLES.
- Same request with DCM_RAMP_EN undefined: a single step, 16 -> 40.
- Current 40, thermal_alarm=1, thermal_mult=24: next step goes directly to 24. Alarm drop: ramp back 28, 32, 36, 40.
- host_mult=200: target_mult=64. host_mult=0: target_mult=2.
- dcm_prog_done held low: prog_error=1 after TIMEOUT_CYCLES; current_mult unchanged. A following host_req clears prog_error.
- rst_n asserted during LOAD_M: en and data go 0 immediately; current_mult=0; reprogramming to 16 starts after release.

Source files
------------

// File: rtl/dcm_ctrl_pkg.sv
// Shared types and constants for the DCM_CLKGEN programming path.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package dcm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_D,
    ST_GAP1,
    ST_LOAD_M,
    ST_GAP2,
    ST_GO,
    ST_WAIT_DONE,
    ST_SETTLE
  } state_e;

  // Command bits go out bit 0 first: LOAD_D is 1,0 and LOAD_M is 1,1.
  localparam logic [1:0] CMD_LOAD_D = 2'b01;
  localparam logic [1:0] CMD_LOAD_M = 2'b11;

  localparam int FRAME_LEN = 10;
  localparam int GAP1_LEN  = 3;
  localparam int GAP2_LEN  = 2;

  function automatic logic [7:0] clamp_mult(input logic [7:0] v,
                                            input logic [7:0] lo,
                                            input logic [7:0] hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

endpackage

// File: rtl/dcm_prog_serializer.sv
// Shifts one 10-bit LOAD_D/LOAD_M frame onto PROGEN/PROGDATA.
// Latency: first bit appears the cycle after start; frame_done on the 10th bit.
// Backpressure: none; start must only be pulsed while no frame is in flight.
module dcm_prog_serializer
  import dcm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       is_m,
  input  logic [7:0] value,
  output logic       en,
  output logic       data,
  output logic       frame_done
);

  logic [9:0] sh_q, sh_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (start) begin
      sh_d  = {value, (is_m ? CMD_LOAD_M : CMD_LOAD_D)};
      cnt_d = 4'(FRAME_LEN);
    end else if (cnt_q != 4'd0) begin
      // Zeros shift in behind the frame so data idles low.
      sh_d  = {1'b0, sh_q[9:1]};
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign en         = (cnt_q != 4'd0);
  assign data       = sh_q[0] & en;
  assign frame_done = (cnt_q == 4'd1);

endmodule

// File: rtl/dcm_freq_scheduler.sv
// Arbitrates host/thermal multiplier requests and sequences DCM_CLKGEN D/M programming.
// Latency: 26-cycle frame, then PROGDONE wait, then settle; upward ramp limited when DCM_RAMP_EN is defined.
// Backpressure: none; host_req is always accepted into target_mult, last request wins.
module dcm_freq_scheduler
  import dcm_ctrl_pkg::*;
#(
  parameter int MAXIMUM_MULTIPLIER = 64,
  parameter int MINIMUM_MULTIPLIER = 2,
  parameter int INITIAL_MULTIPLIER = 16,
  parameter int DIVIDER            = 8,
  parameter int MAX_STEP           = 4,
  parameter int SETTLE_CYCLES      = 4096,
  parameter int TIMEOUT_CYCLES     = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_req,
  input  logic [7:0] host_mult,
  input  logic       thermal_alarm,
  input  logic [7:0] thermal_mult,
  input  logic       dcm_prog_done,
  input  logic       dcm_locked,
  output logic       dcm_prog_en,
  output logic       dcm_prog_data,
  output logic       busy,
  output logic [7:0] current_mult,
  output logic [7:0] target_mult,
  output logic       prog_error
);

`ifdef DCM_RAMP_EN
  localparam bit RampEn = 1'b1;
`else
  localparam bit RampEn = 1'b0;
`endif

  localparam logic [7:0]  MaxM        = 8'(MAXIMUM_MULTIPLIER);
  localparam logic [7:0]  MinM        = 8'(MINIMUM_MULTIPLIER);
  localparam logic [7:0]  InitM       = 8'(INITIAL_MULTIPLIER);
  localparam logic [7:0]  DivCode     = 8'(DIVIDER - 1);
  localparam logic [8:0]  Step9       = 9'(MAX_STEP);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] SettleLast  = 16'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cur_q, cur_d;
  logic [7:0]  tgt_q, tgt_d;
  logic [7:0]  next_q, next_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [7:0]  host_c, therm_c, eff, step;
  logic [8:0]  up9;
  logic        ser_start, ser_is_m, ser_en, ser_data, ser_done;
  logic [7:0]  ser_value;

  always_comb begin
    host_c  = clamp_mult(host_mult, MinM, MaxM);
    therm_c = clamp_mult(thermal_mult, MinM, MaxM);
    eff     = (thermal_alarm && (therm_c < tgt_q)) ? therm_c : tgt_q;
    // 9-bit sum so a step near 255 cannot wrap below eff.
    up9     = {1'b0, cur_q} + Step9;
    if (!RampEn || (cur_q == 8'd0) || (eff < cur_q)) begin
      step = eff;
    end else if ({1'b0, eff} < up9) begin
      step = eff;
    end else begin
      step = up9[7:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    next_d    = next_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    tgt_d     = host_req ? host_c : tgt_q;
    ser_start = 1'b0;
    ser_is_m  = 1'b0;
    ser_value = DivCode;
    if (host_req) err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (eff != cur_q) begin
          next_d    = step;
          ser_start = 1'b1;
          state_d   = ST_LOAD_D;
        end
      end
      ST_LOAD_D: begin
        if (ser_done) begin
          cnt_d   = '0;
          state_d = ST_GAP1;
        end
      end
      ST_GAP1: begin
        if (cnt_q == 16'(GAP1_LEN - 1)) begin
          ser_start = 1'b1;
          ser_is_m  = 1'b1;
          ser_value = next_q - 8'd1;
          state_d   = ST_LOAD_M;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_LOAD_M: begin
        if (ser_done) begin
          cnt_d   = '0;
          state_d = ST_GAP2;
        end
      end
      ST_GAP2: begin
        if (cnt_q == 16'(GAP2_LEN - 1)) state_d = ST_GO;
        else                            cnt_d   = cnt_q + 16'd1;
      end
      ST_GO: begin
        cnt_d   = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (dcm_prog_done) begin
          cur_d   = next_q;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else if (cnt_q == TimeoutLast) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SettleLast) begin
          if (!dcm_locked) err_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      tgt_q   <= InitM;
      next_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      next_q  <= next_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  dcm_prog_serializer u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (ser_start),
    .is_m       (ser_is_m),
    .value      (ser_value),
    .en         (ser_en),
    .data       (ser_data),
    .frame_done (ser_done)
  );

  assign dcm_prog_en   = ser_en | (state_q == ST_GO);
  assign dcm_prog_data = ser_data;
  assign busy          = (state_q != ST_IDLE);
  assign current_mult  = cur_q;
  assign target_mult   = tgt_q;
  assign prog_error    = err_q;

endmodule

// File: tb/tb_dcm_freq_scheduler.sv
// Randomized scoreboard bench for dcm_freq_scheduler with a behavioural step model.
module tb_dcm_freq_scheduler;

  localparam int SETTLE  = 40;
  localparam int TIMEOUT = 200;
  localparam int STEP    = 4;
  localparam int MINM    = 2;
  localparam int MAXM    = 64;
  localparam int DIV     = 8;
`ifdef DCM_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_req = 1'b0;
  logic [7:0] host_mult = 8'd0;
  logic       thermal_alarm = 1'b0;
  logic [7:0] thermal_mult = 8'd0;
  logic       dcm_prog_done = 1'b0;
  logic       dcm_locked = 1'b1;
  logic       dcm_prog_en, dcm_prog_data, busy, prog_error;
  logic [7:0] current_mult, target_mult;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int m_cur, m_tgt, m_therm;
  bit m_alarm;
  bit hold_done = 1'b0;
  int cyc = 0;

  dcm_freq_scheduler #(
    .MAXIMUM_MULTIPLIER (MAXM),
    .MINIMUM_MULTIPLIER (MINM),
    .INITIAL_MULTIPLIER (16),
    .DIVIDER            (DIV),
    .MAX_STEP           (STEP),
    .SETTLE_CYCLES      (SETTLE),
    .TIMEOUT_CYCLES     (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host_req      (host_req),
    .host_mult     (host_mult),
    .thermal_alarm (thermal_alarm),
    .thermal_mult  (thermal_mult),
    .dcm_prog_done (dcm_prog_done),
    .dcm_locked    (dcm_locked),
    .dcm_prog_en   (dcm_prog_en),
    .dcm_prog_data (dcm_prog_data),
    .busy          (busy),
    .current_mult  (current_mult),
    .target_mult   (target_mult),
    .prog_error    (prog_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clampm(input int v);
    if (v < MINM) return MINM;
    if (v > MAXM) return MAXM;
    return v;
  endfunction

  // Walks the model multiplier toward the effective target, queueing every programmed value.
  function automatic void plan();
    int eff, nxt;
    eff = m_tgt;
    if (m_alarm && clampm(m_therm) < m_tgt) eff = clampm(m_therm);
    while (m_cur != eff) begin
      if (!RAMP || m_cur == 0 || eff < m_cur) nxt = eff;
      else nxt = (m_cur + STEP < eff) ? m_cur + STEP : eff;
      exp_q.push_back(nxt);
      m_cur = nxt;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_host(input int h);
    host_mult = 8'(h);
    host_req  = 1'b1;
    tick();
    host_req  = 1'b0;
    m_tgt = clampm(h);
    check("target_mult", target_mult, m_tgt);
  endtask

  task automatic set_thermal(input bit a, input int t);
    thermal_alarm = a;
    thermal_mult  = 8'(t);
    m_alarm = a;
    m_therm = t;
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL quiet_timeout: busy=%0d pending=%0d after %0d cycles, expected idle", busy, exp_q.size(), n);
    end
    check("current_mult", current_mult, m_cur);
  endtask

  // Frame decoder and step scoreboard.
  initial begin : monitor
    int bits[16];
    int nb, prev_cur, last_chg, v;
    nb = 0; prev_cur = 0; last_chg = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nb = 0; prev_cur = 0; last_chg = -1;
      end else begin
        if (dcm_prog_en) begin
          if (nb < 16) bits[nb] = int'(dcm_prog_data);
          nb++;
        end else if (nb != 0) begin
          if (nb == 1) begin
            check("go_data", bits[0], 0);
          end else if (nb == 10) begin
            v = 0;
            for (int i = 0; i < 8; i++) v |= bits[i+2] << i;
            if (bits[0] == 1 && bits[1] == 0) begin
              check("d_frame_value", v, DIV - 1);
            end else if (bits[0] == 1 && bits[1] == 1) begin
              if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL m_frame_unexpected: got M code %0d, expected no frame", v);
              end else begin
                check("m_frame_value", v, exp_q[0] - 1);
              end
            end else begin
              checks++; errors++;
              $display("FAIL frame_cmd: got %0d%0d, expected 10 or 11", bits[0], bits[1]);
            end
          end else begin
            checks++; errors++;
            $display("FAIL frame_len: got %0d, expected 1 or 10", nb);
          end
          nb = 0;
        end
        if (int'(current_mult) != prev_cur) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_step: current_mult=%0d, expected no change", current_mult);
          end else begin
            check("step_value", current_mult, exp_q.pop_front());
          end
          if (last_chg >= 0) check("step_spacing", int'(cyc - last_chg >= SETTLE + 26), 1);
          last_chg = cyc;
          prev_cur = current_mult;
        end
      end
    end
  end

  // DCM model: PROGDONE three cycles after GO unless held off.
  initial begin : responder
    int run, pend;
    run = 0; pend = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0; pend = 0; dcm_prog_done = 1'b0;
      end else begin
        dcm_prog_done = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) dcm_prog_done = 1'b1;
        end
        if (!dcm_prog_en && run == 1 && !hold_done) pend = 2;
        run = dcm_prog_en ? run + 1 : 0;
      end
    end
  end

  initial begin : stimulus
    int n, h, cur_before;
    repeat (3) @(posedge clk);
    #1;
    check("rst_prog_en", dcm_prog_en, 0);
    check("rst_prog_data", dcm_prog_data, 0);
    check("rst_busy", busy, 0);
    check("rst_current", current_mult, 0);
    check("rst_target", target_mult, 16);
    check("rst_error", prog_error, 0);

    m_cur = 0; m_tgt = 16; m_alarm = 0; m_therm = 0;
    plan();
    rst_n = 1'b1;
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    n = 0;
    while (busy && n < 29 + SETTLE + 100) begin tick(); n++; end
    check("first_busy_cycles", n, 29 + SETTLE);
    wait_quiet(500);

    // 16 -> 40 ramp.
    do_host(40);
    if (RAMP) for (int s = 20; s <= 40; s += 4) exp_q.push_back(s);
    else exp_q.push_back(40);
    m_cur = 40;
    wait_quiet(2000);

    // Thermal cap drops straight to 24, then climbs back.
    set_thermal(1'b1, 24);
    exp_q.push_back(24);
    m_cur = 24;
    wait_quiet(1000);
    check("target_under_cap", target_mult, 40);
    set_thermal(1'b0, 24);
    if (RAMP) for (int s = 28; s <= 40; s += 4) exp_q.push_back(s);
    else exp_q.push_back(40);
    m_cur = 40;
    wait_quiet(2000);

    do_host(200);
    check("clamp_high", target_mult, 64);
    plan();
    wait_quiet(3000);
    do_host(0);
    check("clamp_low", target_mult, 2);
    plan();
    wait_quiet(3000);

    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) do_host(int'($urandom_range(0, 255)));
      else set_thermal(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      plan();
      wait_quiet(3000);
    end

    // PROGDONE withheld: timeout error, multiplier unchanged, then recovery.
    set_thermal(1'b0, 0);
    plan();
    wait_quiet(3000);
    cur_before = m_cur;
    h = (m_cur == 30) ? 50 : 30;
    hold_done = 1'b1;
    do_host(h);
    plan();
    n = 0;
    while (!prog_error && n < TIMEOUT + 200) begin tick(); n++; end
    check("timeout_error", prog_error, 1);
    check("timeout_current_kept", current_mult, cur_before);
    hold_done = 1'b0;
    wait_quiet(3000);
    check("error_sticky", prog_error, 1);
    do_host(h);
    check("error_cleared", prog_error, 0);

    // Lock lost at end of settle.
    h = (m_cur == 20) ? 10 : 20;
    dcm_locked = 1'b0;
    do_host(h);
    plan();
    wait_quiet(3000);
    check("lock_loss_error", prog_error, 1);
    dcm_locked = 1'b1;
    do_host(h);
    check("lock_error_cleared", prog_error, 0);

    // Reset during LOAD_M.
    h = (m_cur == 48) ? 12 : 48;
    do_host(h);
    plan();
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    repeat (14) tick();
    check("pre_reset_en", dcm_prog_en, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_prog_en", dcm_prog_en, 0);
    check("midrst_prog_data", dcm_prog_data, 0);
    check("midrst_current", current_mult, 0);
    check("midrst_busy", busy, 0);
    check("midrst_target", target_mult, 16);
    exp_q.delete();
    m_cur = 0; m_tgt = 16;
    tick();
    rst_n = 1'b1;
    plan();
    wait_quiet(1000);
    check("post_reset_target", target_mult, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
